// File: rtl/mem_copy_dma_pkg.sv
// mem_copy_dma_pkg: shared types and bus field constants for the copy DMA.
// Used by mem_copy_dma and any other initiator sharing the peripheral bus.
package mem_copy_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] WORD_BYTES      = 32'd4;
    localparam logic [3:0]  WRITE_MASK_FULL = 4'hF;
    localparam logic [3:0]  WRITE_MASK_NONE = 4'h0;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator copying a block of 32-bit words, src -> dst.
// Ports: cmd valid/ready + src/dst/len, abort, busy/done; single-cycle bus
// (address, sel, read, write_mask, write_value out; read_value in).
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 cmd_valid_in,
    output logic                 cmd_ready_out,
    input  logic [31:0]          cmd_src_in,
    input  logic [31:0]          cmd_dst_in,
    input  logic [LEN_WIDTH-1:0] cmd_len_in,
    input  logic                 abort_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [31:0]          address_out,
    output logic                 sel_out,
    output logic                 read_out,
    output logic [3:0]           write_mask_out,
    output logic [31:0]          write_value_out,
    input  logic [31:0]          read_value_in
);

    state_e               state;
    logic [31:0]          src;
    logic [31:0]          dst;
    logic [31:0]          data;
    logic [LEN_WIDTH-1:0] remaining;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            data      <= '0;
            remaining <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_in) begin
                        src       <= word_align(cmd_src_in);
                        dst       <= word_align(cmd_dst_in);
                        remaining <= cmd_len_in;
                        state     <= (cmd_len_in == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (abort_in) begin
                        state     <= IDLE;
                        remaining <= '0;
                    end else begin
                        data  <= read_value_in;
                        src   <= src + WORD_BYTES;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    // The write on the bus this cycle completes even on abort.
                    if (abort_in) begin
                        state     <= IDLE;
                        remaining <= '0;
                    end else begin
                        dst       <= dst + WORD_BYTES;
                        remaining <= remaining - LEN_WIDTH'(1);
                        state     <= (remaining == LEN_WIDTH'(1)) ? DONE : READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode: outputs depend only on registered state and addresses.
    always_comb begin
        cmd_ready_out   = 1'b0;
        busy_out        = 1'b0;
        done_out        = 1'b0;
        sel_out         = 1'b0;
        read_out        = 1'b0;
        write_mask_out  = WRITE_MASK_NONE;
        address_out     = '0;
        write_value_out = '0;
        unique case (state)
            IDLE: begin
                cmd_ready_out = 1'b1;
            end
            READ: begin
                busy_out    = 1'b1;
                sel_out     = 1'b1;
                read_out    = 1'b1;
                address_out = src;
            end
            WRITE: begin
                busy_out        = 1'b1;
                sel_out         = 1'b1;
                write_mask_out  = WRITE_MASK_FULL;
                address_out     = dst;
                write_value_out = data;
            end
            DONE: begin
                done_out = 1'b1;
            end
            default: begin
                cmd_ready_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed bench for mem_copy_dma with a 256-word memory.
// Unwritten words read as 32'hD000_0000 | word index (address bits [9:2]).
module tb_mem_copy_dma;

    logic        clk;
    logic        reset_;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [31:0] cmd_src_in;
    logic [31:0] cmd_dst_in;
    logic [15:0] cmd_len_in;
    logic        abort_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] address_out;
    logic        sel_out;
    logic        read_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_acc   = 0;

    logic [31:0] mem [256];
    bit          wr_flag [256];
    bit          q_wr [$];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];

    mem_copy_dma #(.LEN_WIDTH(16)) dut (
        .clk             (clk),
        .reset_          (reset_),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_src_in      (cmd_src_in),
        .cmd_dst_in      (cmd_dst_in),
        .cmd_len_in      (cmd_len_in),
        .abort_in        (abort_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .address_out     (address_out),
        .sel_out         (sel_out),
        .read_out        (read_out),
        .write_mask_out  (write_mask_out),
        .write_value_out (write_value_out),
        .read_value_in   (read_value_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [7:0] idx);
        return wr_flag[idx] ? mem[idx] : (32'hD000_0000 | {24'h0, idx});
    endfunction

    assign read_value_in = mem_rd(address_out[9:2]);

    always @(posedge clk) begin
        if (reset_ && sel_out) begin
            q_wr.push_back(write_mask_out == 4'hF);
            q_addr.push_back(address_out);
            q_data.push_back(read_out ? read_value_in : write_value_out);
            if (write_mask_out == 4'hF) begin
                mem[address_out[9:2]]     = write_value_out;
                wr_flag[address_out[9:2]] = 1'b1;
            end
        end
        if (reset_ && done_out) n_done++;
        if (reset_ && cmd_valid_in && cmd_ready_out) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input int i, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (i >= q_addr.size()) begin
            chk({tag, "_missing"}, 32'(q_addr.size()), 32'(i + 1));
        end else begin
            chk({tag, "_kind"}, {31'h0, q_wr[i]}, {31'h0, wr});
            chk({tag, "_addr"}, q_addr[i], a);
            chk({tag, "_data"}, q_data[i], d);
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] l);
        @(posedge clk); #1;
        cmd_valid_in = 1'b1;
        cmd_src_in   = s;
        cmd_dst_in   = d;
        cmd_len_in   = l;
        @(posedge clk); #1;
        cmd_valid_in = 1'b0;
    endtask

    // Returns the cycle (1 = cycle after the accept edge) done_out is seen.
    task automatic wait_done(input int lim, output int cyc);
        cyc = -1;
        for (int k = 1; k <= lim; k++) begin
            if (done_out) begin
                cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int cyc;
    int base;
    int d0;
    int a0;

    initial begin
        reset_       = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_src_in   = '0;
        cmd_dst_in   = '0;
        cmd_len_in   = '0;
        abort_in     = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, cmd_ready_out}, 32'h1);
        chk("rst_sel", {31'h0, sel_out}, 32'h0);
        reset_ = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {31'h0, cmd_ready_out}, 32'h1);
        chk("idle_sel", {31'h0, sel_out}, 32'h0);
        chk("idle_mask", {28'h0, write_mask_out}, 32'h0);
        chk("idle_busy", {31'h0, busy_out}, 32'h0);
        chk("idle_done", {31'h0, done_out}, 32'h0);
        chk("idle_addr", address_out, 32'h0);
        chk("idle_wval", write_value_out, 32'h0);

        // Basic copy 0x100 -> 0x200, 3 words
        base = q_addr.size();
        issue(32'h100, 32'h200, 16'd3);
        chk("basic_busy", {31'h0, busy_out}, 32'h1);
        wait_done(30, cyc);
        chk("basic_done_cyc", 32'(cyc), 32'd7);
        @(posedge clk); #1;
        chk("basic_nbus", 32'(q_addr.size() - base), 32'd6);
        chk_bus("basic_r0", base + 0, 1'b0, 32'h100, 32'hD000_0040);
        chk_bus("basic_w0", base + 1, 1'b1, 32'h200, 32'hD000_0040);
        chk_bus("basic_r1", base + 2, 1'b0, 32'h104, 32'hD000_0041);
        chk_bus("basic_w1", base + 3, 1'b1, 32'h204, 32'hD000_0041);
        chk_bus("basic_r2", base + 4, 1'b0, 32'h108, 32'hD000_0042);
        chk_bus("basic_w2", base + 5, 1'b1, 32'h208, 32'hD000_0042);
        chk("basic_mem2", mem_rd(8'h82), 32'hD000_0042);
        chk("basic_idle", {31'h0, cmd_ready_out}, 32'h1);

        // Zero length
        base = q_addr.size();
        issue(32'h40, 32'h80, 16'd0);
        wait_done(10, cyc);
        chk("zero_done_cyc", 32'(cyc), 32'd1);
        chk("zero_ready_in_done", {31'h0, cmd_ready_out}, 32'h0);
        @(posedge clk); #1;
        chk("zero_idle", {31'h0, cmd_ready_out}, 32'h1);
        chk("zero_nbus", 32'(q_addr.size() - base), 32'd0);

        // Misaligned addresses and 32-bit wrap
        base = q_addr.size();
        issue(32'hFFFF_FFFF, 32'h0000_0013, 16'd2);
        wait_done(20, cyc);
        chk("wrap_done_cyc", 32'(cyc), 32'd5);
        chk_bus("wrap_r0", base + 0, 1'b0, 32'hFFFF_FFFC, 32'hD000_00FF);
        chk_bus("wrap_w0", base + 1, 1'b1, 32'h0000_0010, 32'hD000_00FF);
        chk_bus("wrap_r1", base + 2, 1'b0, 32'h0000_0000, 32'hD000_0000);
        chk_bus("wrap_w1", base + 3, 1'b1, 32'h0000_0014, 32'hD000_0000);
        @(posedge clk); #1;

        // Abort in the second WRITE cycle
        base = q_addr.size();
        d0   = n_done;
        issue(32'h300, 32'h380, 16'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_write", {28'h0, write_mask_out}, 32'hF);
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        chk("abort_ready", {31'h0, cmd_ready_out}, 32'h1);
        chk("abort_busy", {31'h0, busy_out}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_nbus", 32'(q_addr.size() - base), 32'd4);
        chk("abort_w1_mem", mem_rd(8'hE1), 32'hD000_00C1);
        chk("abort_no_w2", {31'h0, wr_flag[8'hE2]}, 32'h0);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);

        // Command with abort high in IDLE is accepted
        @(posedge clk); #1;
        cmd_valid_in = 1'b1;
        abort_in     = 1'b1;
        cmd_src_in   = 32'h100;
        cmd_dst_in   = 32'h240;
        cmd_len_in   = 16'd1;
        @(posedge clk); #1;
        cmd_valid_in = 1'b0;
        abort_in     = 1'b0;
        chk("idle_abort_busy", {31'h0, busy_out}, 32'h1);
        wait_done(10, cyc);
        chk("idle_abort_done", 32'(cyc), 32'd3);
        @(posedge clk); #1;

        // cmd_valid held during a transfer
        a0 = n_acc;
        @(posedge clk); #1;
        cmd_valid_in = 1'b1;
        cmd_src_in   = 32'h100;
        cmd_dst_in   = 32'h280;
        cmd_len_in   = 16'd2;
        @(posedge clk); #1;
        wait_done(20, cyc);
        cmd_valid_in = 1'b0;
        chk("hold_done_cyc", 32'(cyc), 32'd5);
        @(posedge clk); #1;
        chk("hold_accepts", 32'(n_acc - a0), 32'd1);
        chk("hold_mem1", mem_rd(8'hA1), 32'hD000_0041);

        // Reset mid-READ
        issue(32'h100, 32'h2C0, 16'd3);
        chk("rr_sel_before", {31'h0, sel_out}, 32'h1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("rr_sel_async", {31'h0, sel_out}, 32'h0);
        chk("rr_read", {31'h0, read_out}, 32'h0);
        chk("rr_ready", {31'h0, cmd_ready_out}, 32'h1);
        chk("rr_busy", {31'h0, busy_out}, 32'h0);
        chk("rr_addr", address_out, 32'h0);
        chk("rr_mask", {28'h0, write_mask_out}, 32'h0);
        chk("rr_wval", write_value_out, 32'h0);
        @(posedge clk); #1;
        reset_ = 1'b1;
        @(posedge clk); #1;
        chk("rr_idle_after", {31'h0, cmd_ready_out}, 32'h1);
        chk("rr_done_after", {31'h0, done_out}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Memory-bus initiator that copies a block of 32-bit words from a source address to a destination address.
- Drives the same single-cycle bus that peripherals such as the timer respond to: sel, read, write_mask, write_value out; read_value in, valid combinationally in the same cycle as sel.
- Sits beside the CPU core on the peripheral bus. A 2:1 bus mux outside this block picks the initiator.
- Command comes in via a valid/ready handshake. A one-cycle done pulse reports completion.

Parameters:
- LEN_WIDTH, 16, width of the word-count field; maximum transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  clock
- reset_  input  1  asynchronous active-low reset
- cmd_valid_in  input  1  command request
- cmd_ready_out  output  1  block can accept a command (high only in IDLE)
- cmd_src_in  input  32  source byte address; bits [1:0] ignored
- cmd_dst_in  input  32  destination byte address; bits [1:0] ignored
- cmd_len_in  input  LEN_WIDTH  number of words to copy
- abort_in  input  1  synchronous abort of the transfer in progress
- busy_out  output  1  transfer in progress
- done_out  output  1  one-cycle pulse on normal completion
- address_out  output  32  bus address, bits [1:0] always 0
- sel_out  output  1  bus select
- read_out  output  1  bus read strobe
- write_mask_out  output  4  byte write enables
- write_value_out  output  32  bus write data
- read_value_in  input  32  bus read data, valid in the same cycle as sel_out/read_out

Behaviour:
- Reset (reset_ low, asynchronous): state IDLE; src/dst/remaining/data registers 0.
- Output values during and after reset: cmd_ready_out=1, busy_out=0, done_out=0, sel_out=0, read_out=0, write_mask_out=0, address_out=0, write_value_out=0.
- States: IDLE, READ, WRITE, DONE. All bus outputs are decoded from registered state and address (Moore). No combinational path from read_value_in to any output.
- IDLE:
  - cmd_ready_out=1.
  - On cmd_valid_in&&cmd_ready_out: latch src/dst with bits [1:0] cleared, latch len.
  - len!=0 -> READ; len==0 -> DONE, with no bus access.
- READ:
  - sel_out=1, read_out=1, write_mask_out=0, address_out=src.
  - At the clock edge: capture read_value_in into the data register, src+=4, -> WRITE.
- WRITE:
  - sel_out=1, read_out=0, write_mask_out=4'hF, address_out=dst, write_value_out=data register.
  - At the clock edge: dst+=4, remaining-=1. remaining was 1 -> DONE, else -> READ.
- DONE: done_out=1 for exactly one cycle, busy_out=0, -> IDLE. cmd_ready_out=0 in DONE.
- busy_out=1 in READ and WRITE only.
- Throughput: 2 cycles per word. For len=N>0, done_out is high in cycle 2N+1 after the accept edge.
- Address arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no error.
- abort_in, sampled in READ or WRITE:
  - Next state IDLE, no done pulse, remaining cleared.
  - Bus outputs for the current cycle are unaffected, so a WRITE cycle in flight completes its write.
  - abort_in is ignored in IDLE and DONE.
- A command presented with abort_in high in IDLE is accepted normally.
- cmd_valid_in while not in IDLE is ignored; cmd inputs are only sampled at the accept edge.
- Overlapping source and destination ranges: plain ascending word copy, no overlap correction.
- Reset asserted mid-transfer: immediate return to reset values; sel_out drops asynchronously.

Decomposition:
- Shared package mem_copy_dma_pkg:
  - state enum typedef (IDLE, READ, WRITE, DONE)
  - WORD_BYTES=4
  - WRITE_MASK_FULL=4'hF
  - WRITE_MASK_NONE=4'h0
- Bus field constants live in the package so the bus mux and future initiators share them.
- No sub-module. The FSM, two address counters and the word counter fit in one module.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset_ low 3 cycles, release.
  - Required: cmd_ready_out=1, sel_out=0, write_mask_out=0, busy_out=0, done_out=0.
- Basic copy:
  - Stimulus: src=32'h0000_0100, dst=32'h0000_0200, len=3; memory model holds 11,22,33 at 0x100/0x104/0x108.
  - Required: bus sequence R100,W200(11),R104,W204(22),R108,W208(33); done_out high in cycle 7 after accept; memory at 0x200..0x208 = 11,22,33.
- Zero length:
  - Stimulus: len=0.
  - Required: no sel_out for the whole command; done_out high in cycle 1 after accept; then IDLE.
- Misaligned and wrap:
  - Stimulus: src=32'hFFFF_FFFF, dst=32'h0000_0013, len=2.
  - Required: reads from 0xFFFF_FFFC then 0x0000_0000; writes to 0x10 then 0x14.
- Abort during WRITE:
  - Stimulus: len=4; assert abort_in in the second WRITE cycle.
  - Required: exactly two writes occur; next cycle IDLE, cmd_ready_out=1; done_out never pulses.
- Busy and reset:
  - Stimulus: cmd_valid_in held high during a len=2 transfer; then start a new transfer and pull reset_ low mid-READ.
  - Required: only one command accepted before IDLE; reset drops sel_out in the same cycle without waiting for a clock edge; all outputs return to their reset values.
